adder_error_monitor: RTL

- Sits directly downstream of the 16-bit Kogge-Stone adder (exact or approximated netlist) in the evaluation datapath.
- Each cycle it can consume one operand pair X, Y together with the 17-bit sum the adder under test produced for that pair.
- Computes the exact reference sum internally and accumulates error statistics over a programmed number of samples: error count, maximum error distance and sum of error distances.
- Statistics feed the approximation-quality scoring for pruned netlists.

---
 rtl/adder_error_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adder_error_monitor.sv
// rtl/adder_error_monitor.sv - error statistics monitor for an adder under test
module adder_error_monitor #(
  parameter int W         = 16,
  parameter int N_SAMPLES = 1000,
  parameter int CNT_W     = 32,
  parameter int ACC_W     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W:0]       s_dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [W:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  // Count value at which the accepted sample is the last one of the run
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

  state_t state;

  logic accept;
  logic start_ok;

  // Stage 1: reference sum and captured adder output
  logic         v1;
  logic [W:0]   exact1;
  logic [W:0]   sdut1;

  // Stage 2: error distance
  logic         v2;
  logic [W:0]   ed2;

  logic signed [W+1:0] diff;
  logic        [W+1:0] diff_abs;
  logic        [ACC_W:0] sum_next;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state == IDLE || state == FIN);

  // Signed difference at W+2 bits so the magnitude always fits in W+1 bits
  always_comb begin
    diff     = $signed({1'b0, exact1}) - $signed({1'b0, sdut1});
    diff_abs = diff[W+1] ? (~diff + 1'b1) : diff;
    sum_next = {1'b0, sum_ed} + (ACC_W+1)'(ed2);
  end

  // Run control with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          if (accept && sample_count == N_LAST) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage pipeline: reference sum, then absolute error distance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      exact1 <= '0;
      sdut1  <= '0;
      ed2    <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        exact1 <= {1'b0, x} + {1'b0, y};
        sdut1  <= s_dut;
      end
      if (v1) begin
        ed2 <= diff_abs[W:0];
      end
    end
  end

  // Statistics: cleared on an accepted start, updated from stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else if (start_ok) begin
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else begin
      if (accept) begin
        sample_count <= sample_count + 1'b1;
      end
      if (v2) begin
        if (ed2 != '0) begin
          err_count <= err_count + 1'b1;
        end
        if (ed2 > max_ed) begin
          max_ed <= ed2;
        end
        // Saturation is sticky because all-ones plus anything stays clamped
        sum_ed <= sum_next[ACC_W] ? {ACC_W{1'b1}} : sum_next[ACC_W-1:0];
      end
    end
  end

endmodule
